// File: rtl/jpeg_rle_pkg.sv
// Shared constants, FSM states and symbol layout for the JPEG run-length stages.
package jpeg_rle_pkg;
    localparam int COEF_W_DEF = 8;
    localparam int LANES_DEF  = 8;
    localparam int BEATS_DEF  = 8;
    localparam int RUN_W      = 6;

    localparam logic [3:0]       ZRL_RUN = 4'd15;
    localparam logic [RUN_W-1:0] MAX_RUN = 6'd15;

    typedef enum logic [1:0] {LOAD, SCAN, ZRL, END} rle_state_t;

    typedef struct packed {
        logic [3:0]            run;
        logic [COEF_W_DEF-1:0] val;
        logic                  dc;
        logic                  eob;
    } rle_sym_t;
endpackage

// File: rtl/rle_block_sequencer_if.sv
// Beat input and symbol output handshakes of the RLE block sequencer.
interface rle_block_sequencer_if
    import jpeg_rle_pkg::*;
#(
    parameter int COEF_W = COEF_W_DEF,
    parameter int LANES  = LANES_DEF
);
    logic [LANES*COEF_W-1:0] in_data;
    logic                    in_valid;
    logic                    in_ready;
    logic [3:0]              out_run;
    logic [COEF_W-1:0]       out_val;
    logic                    out_dc;
    logic                    out_eob;
    logic                    out_valid;
    logic                    out_ready;
    logic                    block_done;

    modport master (
        output in_data, in_valid, out_ready,
        input  in_ready, out_run, out_val, out_dc, out_eob, out_valid, block_done
    );

    modport slave (
        input  in_data, in_valid, out_ready,
        output in_ready, out_run, out_val, out_dc, out_eob, out_valid, block_done
    );
endinterface

// File: rtl/rle_lane_mask.sv
// Per-lane nonzero flags of one beat; bit i is lane i (lane 0 sits in the MSBs).
module rle_lane_mask
    import jpeg_rle_pkg::*;
#(
    parameter int COEF_W = COEF_W_DEF,
    parameter int LANES  = LANES_DEF
) (
    input  logic [LANES*COEF_W-1:0] data,
    output logic [LANES-1:0]        mask
);
    always_comb begin
        mask = '0;
        for (int i = 0; i < LANES; i++) begin
            mask[i] = |data[(LANES-1-i)*COEF_W +: COEF_W];
        end
    end
endmodule

// File: rtl/rle_block_sequencer.sv
// Walks a 64-coefficient block one lane per cycle and emits JPEG (run, value)
// symbols with ZRL and EOB insertion, the zero run carried across beats.
module rle_block_sequencer
    import jpeg_rle_pkg::*;
#(
    parameter int COEF_W = COEF_W_DEF,
    parameter int LANES  = LANES_DEF,
    parameter int BEATS  = BEATS_DEF
) (
    input logic                 clk,
    input logic                 rst,
    rle_block_sequencer_if.slave bus
);
    localparam int LANE_W = $clog2(LANES);
    localparam int BEAT_W = $clog2(BEATS);

    rle_state_t              state, next_state;
    logic [LANE_W-1:0]       lane, lane_next;
    logic [BEAT_W-1:0]       beat, beat_next;
    logic [RUN_W-1:0]        run, run_next, run_less_zrl;
    logic [LANES*COEF_W-1:0] beat_data;
    logic [LANES-1:0]        nz_mask;
    logic [COEF_W-1:0]       coef;
    rle_sym_t                sym, sym_next;
    logic                    out_valid_q, block_done_q;
    logic                    emit, load_beat, done_next;
    logic                    stall, lane_nz, is_dc, last_lane, last_beat;

    rle_lane_mask #(.COEF_W(COEF_W), .LANES(LANES)) u_mask (
        .data (beat_data),
        .mask (nz_mask)
    );

    // A symbol waiting on a busy consumer freezes the whole sequencer.
    assign stall        = out_valid_q && !bus.out_ready;
    assign coef         = beat_data[(LANES-1-int'(lane))*COEF_W +: COEF_W];
    assign lane_nz      = nz_mask[lane];
    assign is_dc        = (beat == '0) && (lane == '0);
    assign last_lane    = lane == LANE_W'(LANES-1);
    assign last_beat    = beat == BEAT_W'(BEATS-1);
    assign run_less_zrl = run - RUN_W'(16);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= LOAD;
        else     state <= next_state;
    end

    always_comb begin
        next_state = state;
        if (!stall) begin
            unique case (state)
                LOAD: if (bus.in_valid) next_state = SCAN;
                SCAN: begin
                    if (lane_nz && !is_dc && run > MAX_RUN) next_state = ZRL;
                    else if (last_lane)                     next_state = last_beat ? END : LOAD;
                end
                ZRL:  if (run_less_zrl <= MAX_RUN) next_state = SCAN;
                END:  if (run == '0) next_state = LOAD;
                default: next_state = LOAD;
            endcase
        end
    end

    // END emits EOB first and clears run, so the following END cycle (slot free)
    // is the one in which the last symbol of the block has been accepted.
    always_comb begin
        lane_next = lane;
        beat_next = beat;
        run_next  = run;
        sym_next  = sym;
        emit      = 1'b0;
        load_beat = 1'b0;
        done_next = 1'b0;
        if (!stall) begin
            unique case (state)
                LOAD: begin
                    if (bus.in_valid) begin
                        load_beat = 1'b1;
                        lane_next = '0;
                    end
                end
                SCAN: begin
                    if (is_dc) begin
                        emit     = 1'b1;
                        sym_next = '{run: 4'd0, val: coef, dc: 1'b1, eob: 1'b0};
                        run_next = '0;
                    end else if (!lane_nz) begin
                        run_next = run + RUN_W'(1);
                    end else if (run <= MAX_RUN) begin
                        emit     = 1'b1;
                        sym_next = '{run: run[3:0], val: coef, dc: 1'b0, eob: 1'b0};
                        run_next = '0;
                    end
                    if (is_dc || !lane_nz || run <= MAX_RUN) begin
                        lane_next = lane + LANE_W'(1);
                        if (last_lane && !last_beat) beat_next = beat + BEAT_W'(1);
                    end
                end
                ZRL: begin
                    emit     = 1'b1;
                    sym_next = '{run: ZRL_RUN, val: '0, dc: 1'b0, eob: 1'b0};
                    run_next = run_less_zrl;
                end
                END: begin
                    if (run != '0) begin
                        emit     = 1'b1;
                        sym_next = '{run: 4'd0, val: '0, dc: 1'b0, eob: 1'b1};
                        run_next = '0;
                    end else begin
                        done_next = 1'b1;
                        beat_next = '0;
                        lane_next = '0;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lane         <= '0;
            beat         <= '0;
            run          <= '0;
            beat_data    <= '0;
            sym          <= '0;
            out_valid_q  <= 1'b0;
            block_done_q <= 1'b0;
        end else begin
            lane         <= lane_next;
            beat         <= beat_next;
            run          <= run_next;
            sym          <= sym_next;
            block_done_q <= done_next;
            if (load_beat) beat_data   <= bus.in_data;
            if (!stall)    out_valid_q <= emit;
        end
    end

    assign bus.in_ready   = (state == LOAD) && !stall && !rst;
    assign bus.out_run    = sym.run;
    assign bus.out_val    = sym.val;
    assign bus.out_dc     = sym.dc;
    assign bus.out_eob    = sym.eob;
    assign bus.out_valid  = out_valid_q;
    assign bus.block_done = block_done_q;
endmodule

// File: tb/tb_rle_block_sequencer.sv
// Bench for rle_block_sequencer: directed symbol tables, stall/reset/back-to-back
// sequences, and random blocks against a coefficient-level JPEG RLE model.
module tb_rle_block_sequencer;
    logic clk = 1'b0;
    logic rst;

    rle_block_sequencer_if #(.COEF_W(8), .LANES(8)) bus ();

    rle_block_sequencer #(.COEF_W(8), .LANES(8), .BEATS(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0]       dc;
        logic [1:0][5:0]  pos;
        logic [1:0][7:0]  val;
        logic [2:0]       n_exp;
        logic [4:0][13:0] exp;
    } vec_t;

    vec_t        vecs [6];
    logic [7:0]  blocks [4][64];
    logic [13:0] got_q [$];
    logic [13:0] exp_q [$];
    int          vectors = 0;
    int          miscompares = 0;

    function automatic logic [13:0] mk(input logic [3:0] r, input logic [7:0] v,
                                       input logic d, input logic e);
        return {r, v, d, e};
    endfunction

    task automatic check_output(input string name, input logic [31:0] actual,
                                input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, wanted 0x%0h", name, actual, expected);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check_output({tag, "_out_valid"}, 32'(bus.out_valid), 32'd0);
        check_output({tag, "_out_sym"}, 32'({bus.out_run, bus.out_val, bus.out_dc, bus.out_eob}), 32'd0);
        check_output({tag, "_block_done"}, 32'(bus.block_done), 32'd0);
        check_output({tag, "_in_ready"}, 32'(bus.in_ready), 32'd0);
    endtask

    function automatic logic [63:0] beat_word(input int g);
        logic [63:0] w;
        w = '0;
        for (int l = 0; l < 8; l++) w[(7-l)*8 +: 8] = blocks[g/8][(g%8)*8 + l];
        return w;
    endfunction

    // Reference: plain JPEG AC run-length rules over the 64 zig-zag coefficients.
    function automatic void build_expected(input int nblk);
        int run;
        exp_q.delete();
        for (int b = 0; b < nblk; b++) begin
            run = 0;
            exp_q.push_back(mk(4'd0, blocks[b][0], 1'b1, 1'b0));
            for (int k = 1; k < 64; k++) begin
                if (blocks[b][k] == 8'd0) begin
                    run++;
                end else begin
                    while (run > 15) begin
                        exp_q.push_back(mk(4'd15, 8'd0, 1'b0, 1'b0));
                        run -= 16;
                    end
                    exp_q.push_back(mk(4'(run), blocks[b][k], 1'b0, 1'b0));
                    run = 0;
                end
            end
            if (run > 0) exp_q.push_back(mk(4'd0, 8'd0, 1'b0, 1'b1));
        end
    endfunction

    // mode 0: out_ready high; 1: random; 2: low for cycles 12..16 only.
    task automatic apply_stimulus(input int nblk, input int mode, input int gap_pct,
                                  output int stalls);
        int          beat_idx, cycles, done_cnt;
        logic [13:0] cur, held;
        logic        held_valid;
        got_q.delete();
        beat_idx = 0; cycles = 0; done_cnt = 0; stalls = 0; held_valid = 1'b0; held = '0;
        while (done_cnt < nblk && cycles < 4000) begin
            case (mode)
                0:       bus.out_ready = 1'b1;
                1:       bus.out_ready = ($urandom_range(99) < 70);
                default: bus.out_ready = !(cycles >= 12 && cycles < 17);
            endcase
            if (beat_idx < nblk * 8 && $urandom_range(99) >= gap_pct) begin
                bus.in_valid = 1'b1;
                bus.in_data  = beat_word(beat_idx);
            end else begin
                bus.in_valid = 1'b0;
                bus.in_data  = '0;
            end
            #1;
            cur = {bus.out_run, bus.out_val, bus.out_dc, bus.out_eob};
            if (held_valid) begin
                check_output("stall_valid_hold", 32'(bus.out_valid), 32'd1);
                check_output("stall_sym_hold", 32'(cur), 32'(held));
            end
            if (bus.out_valid && !bus.out_ready) begin
                stalls++;
                check_output("stall_in_ready", 32'(bus.in_ready), 32'd0);
            end
            held_valid = bus.out_valid && !bus.out_ready;
            held       = cur;
            if (bus.out_valid && bus.out_ready) got_q.push_back(cur);
            if (bus.in_valid && bus.in_ready) beat_idx++;
            @(posedge clk);
            @(negedge clk);
            if (bus.block_done) done_cnt++;
            cycles++;
        end
        check_output("blocks_done", 32'(done_cnt), 32'(nblk));
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_output("done_pulse_width", 32'(bus.block_done), 32'd0);
    endtask

    task automatic compare_syms(input string tag);
        check_output({tag, "_count"}, 32'(got_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
            check_output($sformatf("%s_sym%0d", tag, i), 32'(got_q[i]), 32'(exp_q[i]));
    endtask

    task automatic clear_blocks();
        for (int b = 0; b < 4; b++)
            for (int k = 0; k < 64; k++) blocks[b][k] = 8'd0;
    endtask

    task automatic random_blocks(input int nblk);
        int dens;
        for (int b = 0; b < nblk; b++) begin
            dens = ($urandom_range(2) == 0) ? 5 : (($urandom_range(1) == 1) ? 25 : 70);
            for (int k = 0; k < 64; k++)
                blocks[b][k] = ($urandom_range(99) < dens) ? 8'($urandom_range(255, 1)) : 8'd0;
        end
    endtask

    initial begin
        int stalls;
        int acc;

        // Directed table: DC, up to two AC positions/values, expected symbol list.
        for (int i = 0; i < 6; i++) vecs[i] = '0;
        vecs[0].n_exp = 3'd2;
        vecs[0].exp[0] = mk(4'd0, 8'h00, 1'b1, 1'b0);  vecs[0].exp[1] = mk(4'd0, 8'h00, 1'b0, 1'b1);
        vecs[1].dc = 8'd5; vecs[1].pos[0] = 6'd1; vecs[1].val[0] = 8'd3;
        vecs[1].pos[1] = 6'd20; vecs[1].val[1] = 8'hFE; vecs[1].n_exp = 3'd5;
        vecs[1].exp[0] = mk(4'd0, 8'd5, 1'b1, 1'b0);   vecs[1].exp[1] = mk(4'd0, 8'd3, 1'b0, 1'b0);
        vecs[1].exp[2] = mk(4'd15, 8'd0, 1'b0, 1'b0);  vecs[1].exp[3] = mk(4'd2, 8'hFE, 1'b0, 1'b0);
        vecs[1].exp[4] = mk(4'd0, 8'd0, 1'b0, 1'b1);
        vecs[2].pos[0] = 6'd63; vecs[2].val[0] = 8'd7; vecs[2].n_exp = 3'd5;
        vecs[2].exp[0] = mk(4'd0, 8'd0, 1'b1, 1'b0);   vecs[2].exp[1] = mk(4'd15, 8'd0, 1'b0, 1'b0);
        vecs[2].exp[2] = mk(4'd15, 8'd0, 1'b0, 1'b0);  vecs[2].exp[3] = mk(4'd15, 8'd0, 1'b0, 1'b0);
        vecs[2].exp[4] = mk(4'd14, 8'd7, 1'b0, 1'b0);
        vecs[3].dc = 8'h80; vecs[3].pos[0] = 6'd16; vecs[3].val[0] = 8'd1; vecs[3].n_exp = 3'd3;
        vecs[3].exp[0] = mk(4'd0, 8'h80, 1'b1, 1'b0);  vecs[3].exp[1] = mk(4'd15, 8'd1, 1'b0, 1'b0);
        vecs[3].exp[2] = mk(4'd0, 8'd0, 1'b0, 1'b1);
        vecs[4].pos[0] = 6'd17; vecs[4].val[0] = 8'h7F; vecs[4].n_exp = 3'd4;
        vecs[4].exp[0] = mk(4'd0, 8'd0, 1'b1, 1'b0);   vecs[4].exp[1] = mk(4'd15, 8'd0, 1'b0, 1'b0);
        vecs[4].exp[2] = mk(4'd0, 8'h7F, 1'b0, 1'b0);  vecs[4].exp[3] = mk(4'd0, 8'd0, 1'b0, 1'b1);
        vecs[5].dc = 8'd1; vecs[5].pos[0] = 6'd8; vecs[5].val[0] = 8'd4; vecs[5].n_exp = 3'd3;
        vecs[5].exp[0] = mk(4'd0, 8'd1, 1'b1, 1'b0);   vecs[5].exp[1] = mk(4'd7, 8'd4, 1'b0, 1'b0);
        vecs[5].exp[2] = mk(4'd0, 8'd0, 1'b0, 1'b1);

        rst = 1'b1;
        bus.in_valid = 1'b0; bus.in_data = '0; bus.out_ready = 1'b0;
        repeat (2) @(negedge clk);
        check_reset_outputs("por");
        rst = 1'b0;
        #1;
        check_output("in_ready_after_reset", 32'(bus.in_ready), 32'd1);
        @(negedge clk);

        for (int v = 0; v < 6; v++) begin
            clear_blocks();
            blocks[0][0] = vecs[v].dc;
            for (int j = 0; j < 2; j++)
                if (vecs[v].pos[j] != 6'd0) blocks[0][vecs[v].pos[j]] = vecs[v].val[j];
            apply_stimulus(1, 0, 0, stalls);
            exp_q.delete();
            for (int i = 0; i < int'(vecs[v].n_exp); i++) exp_q.push_back(vecs[v].exp[i]);
            compare_syms($sformatf("table%0d", v));
        end

        // Dense block so a symbol is pending throughout the forced stall window.
        for (int k = 0; k < 64; k++) blocks[0][k] = 8'(k + 1);
        apply_stimulus(1, 2, 0, stalls);
        check_output("stall_cycles", 32'(stalls), 32'd5);
        build_expected(1);
        compare_syms("stall_block");

        // Back-to-back: first block ends in a zero run, second starts immediately.
        clear_blocks();
        blocks[0][40] = 8'd3;
        blocks[1][0] = 8'd9; blocks[1][5] = 8'd2;
        apply_stimulus(2, 0, 0, stalls);
        build_expected(2);
        compare_syms("back2back");

        // Reset while scanning beat 3 of a block.
        random_blocks(1);
        bus.out_ready = 1'b1;
        acc = 0;
        for (int c = 0; c < 200 && acc < 4; c++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = beat_word(acc);
            #1;
            if (bus.in_ready) acc++;
            @(posedge clk);
            @(negedge clk);
        end
        check_output("partial_beats", 32'(acc), 32'd4);
        bus.in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        check_reset_outputs("mid_block");
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        random_blocks(1);
        apply_stimulus(1, 1, 20, stalls);
        build_expected(1);
        compare_syms("after_reset");

        for (int r = 0; r < 4; r++) begin
            random_blocks(3);
            apply_stimulus(3, 1, 30, stalls);
            build_expected(3);
            compare_syms($sformatf("random%0d", r));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
